// File: rtl/barrel_pkg.sv
// Shared types for the pipelined barrel shifter: the operation encoding and
// a small helper used to derive the pipeline depth from the level count.
package barrel_pkg;

  // Operation selector as carried on the operand bus.
  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shop_t;

  // Integer ceiling division, used to turn mux levels into register slices.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/barrel_level.sv
// One combinational level of the log shifter. When enabled it moves the data
// by a fixed 2^K positions in the direction and style selected by op; when
// disabled the data passes straight through.
module barrel_level
  import barrel_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  shop_t            op,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  localparam int SH = 1 << K;

  // Fixed-distance shift/rotate; right shifts insert the fill bit so SRL and
  // SRA share one path (fill is 0 for SRL, the original sign for SRA).
  always_comb begin
    result = data;
    if (en) begin
      case (op)
        SH_SLL:         result = {data[WIDTH-SH-1:0], {SH{1'b0}}};
        SH_SRL, SH_SRA: result = {{SH{fill}}, data[WIDTH-1:SH]};
        SH_ROR:         result = {data[SH-1:0], data[WIDTH-1:SH]};
        default:        result = data;
      endcase
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready on both sides.
// SAW mux levels (LSB-first, level k shifts by 2^k) are split into LAT
// register slices of LVL_PER_STAGE levels each; the last slice is the output
// register. Carry and saturation are resolved on entry and ride along.
module barrel_shift_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int LVL_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  localparam int SAW = $clog2(WIDTH);
  localparam int LAT = ceil_div(SAW, LVL_PER_STAGE);

  // Everything a slice needs to finish the operation downstream.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SAW-1:0]   amt;
    shop_t            op;
    logic             fill;
    logic             sat;
    logic             carry;
  } stage_t;

  stage_t           pipe [LAT];
  stage_t           src  [LAT];
  stage_t           nxt  [LAT];
  logic [WIDTH-1:0] stage_end [LAT];
  logic [LAT-1:0]   v;
  logic [LAT:0]     vchain;
  logic [LAT-1:0]   rdy;

  shop_t            op_in;
  logic [SAW-1:0]   low;
  logic [SAW-1:0]   low_m1;
  logic [SAW-1:0]   low_neg;
  logic             sat_in;
  logic             full_in;
  logic             carry_in;

  assign op_in   = shop_t'(in_op);
  assign low     = in_amt[SAW-1:0];
  assign low_m1  = low - SAW'(1);
  assign low_neg = SAW'(0) - low;
  assign sat_in  = |in_amt[WIDTH-1:SAW];
  assign full_in = (in_amt == WIDTH'(WIDTH));

  // Carry is decided from the raw operand so later slices never need it.
  always_comb begin
    carry_in = 1'b0;
    case (op_in)
      SH_SLL: begin
        if (sat_in)          carry_in = full_in & in_data[0];
        else if (low != '0)  carry_in = in_data[low_neg];
      end
      SH_SRL: begin
        if (sat_in)          carry_in = full_in & in_data[WIDTH-1];
        else if (low != '0)  carry_in = in_data[low_m1];
      end
      SH_SRA: begin
        if (sat_in)          carry_in = in_data[WIDTH-1];
        else if (low != '0)  carry_in = in_data[low_m1];
      end
      SH_ROR: begin
        if (low != '0)       carry_in = in_data[low_m1];
      end
      default:               carry_in = 1'b0;
    endcase
  end

  // Source payload for each slice: fresh operand for the first, the previous
  // register for the rest.
  always_comb begin
    src[0].data  = in_data;
    src[0].amt   = low;
    src[0].op    = op_in;
    src[0].fill  = (op_in == SH_SRA) & in_data[WIDTH-1];
    src[0].sat   = sat_in;
    src[0].carry = carry_in;
    for (int s = 1; s < LAT; s++) begin
      src[s] = pipe[s-1];
    end
  end

  for (genvar k = 0; k < SAW; k++) begin : g_level
    localparam int S = k / LVL_PER_STAGE;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    if (k % LVL_PER_STAGE == 0) begin : g_head
      assign din = src[S].data;
    end else begin : g_chain
      assign din = g_level[k-1].dout;
    end
    barrel_level #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_level (
      .data   (din),
      .en     (src[S].amt[k]),
      .op     (src[S].op),
      .fill   (src[S].fill),
      .result (dout)
    );
  end

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    localparam int LAST = ((s + 1) * LVL_PER_STAGE < SAW) ? (s + 1) * LVL_PER_STAGE - 1 : SAW - 1;
    assign stage_end[s] = g_level[LAST].dout;
    // A slice may load when it, or some slice after it, has room, or when
    // the consumer is taking the result.
    assign rdy[s] = out_ready | ~(&v[LAT-1:s]);
  end

  // Next slice contents; out-of-range shifts collapse to the fill pattern
  // just before the output register, rotates ignore saturation.
  always_comb begin
    for (int s = 0; s < LAT; s++) begin
      nxt[s]      = src[s];
      nxt[s].data = stage_end[s];
    end
    if (src[LAT-1].sat && (src[LAT-1].op != SH_ROR)) begin
      nxt[LAT-1].data = {WIDTH{src[LAT-1].fill}};
    end
  end

  assign vchain = {v, in_valid};

  // Slice registers: flush drops everything in flight, otherwise each slice
  // takes its predecessor whenever it is allowed to advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int s = 0; s < LAT; s++) begin
        pipe[s] <= '0;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int s = 0; s < LAT; s++) begin
        if (rdy[s]) begin
          v[s] <= vchain[s];
          if (vchain[s]) begin
            pipe[s] <= nxt[s];
          end
        end
      end
    end
  end

  assign in_ready  = rdy[0] | flush;
  assign out_valid = vchain[LAT];
  assign out_data  = pipe[LAT-1].data;
  assign out_carry = pipe[LAT-1].carry;
  assign out_zero  = (out_data == '0);

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe at WIDTH=16, LVL_PER_STAGE=2.
// A queue of expected results is filled from a plain arithmetic model on
// every input transfer and drained on every output transfer.
module tb_barrel_shift_pipe;

  localparam int WIDTH = 16;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] in_amt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_carry;
  logic        out_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] data;
    logic        carry;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  barrel_shift_pipe #(
    .WIDTH         (WIDTH),
    .LVL_PER_STAGE (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero)
  );

  // Reference result straight from the shift/rotate rules.
  function automatic exp_t refModel(input logic [15:0] d, input logic [15:0] a, input logic [1:0] op);
    exp_t r;
    int n;
    int m;
    logic signed [15:0] sd;
    logic [31:0] dd;
    n = int'(a);
    sd = d;
    dd = {d, d};
    r.data = 16'h0;
    r.carry = 1'b0;
    case (op)
      2'b00: begin
        if (n < 16) r.data = d << n;
        if (n > 0 && n < 16) r.carry = d[16-n];
        else if (n == 16) r.carry = d[0];
      end
      2'b01: begin
        if (n < 16) r.data = d >> n;
        if (n > 0 && n <= 16) r.carry = d[n-1];
      end
      2'b10: begin
        if (n < 16) r.data = 16'(sd >>> n);
        else r.data = {16{d[15]}};
        if (n > 0 && n <= 16) r.carry = d[n-1];
        else if (n > 16) r.carry = d[15];
      end
      default: begin
        m = n % 16;
        r.data = 16'(dd >> m);
        r.carry = (m != 0) ? r.data[15] : 1'b0;
      end
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one operand (called just after a rising edge) and hold it until
  // accepted; returns just after the accept edge with in_valid dropped.
  task automatic applyStimulus(input logic [15:0] d, input logic [15:0] a, input logic [1:0] op, output bit ok);
    in_valid = 1'b1;
    in_data = d;
    in_amt = a;
    in_op = op;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
    if (ok) begin
      @(posedge clk);
      #2;
    end else begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic directedCase(input string name, input logic [15:0] d, input logic [15:0] a,
                              input logic [1:0] op, input logic [15:0] expD, input logic expC);
    bit ok;
    bit seen;
    int edges;
    applyStimulus(d, a, op, ok);
    if (!ok) return;
    edges = 1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
      edges++;
    end
    checkOutput({name, "_valid"}, 32'(seen), 32'd1);
    checkOutput({name, "_latency"}, 32'(edges), 32'(LAT));
    checkOutput({name, "_data"}, 32'(out_data), 32'(expD));
    checkOutput({name, "_carry"}, 32'(out_carry), 32'(expC));
    checkOutput({name, "_zero"}, 32'(out_zero), 32'(expD == 16'h0));
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: sampled mid-cycle, so it sees exactly what the next rising
  // edge will transfer.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      checkOutput("in_ready_rule", 32'(in_ready), 32'((q.size() < LAT) || out_ready || flush));
      if (out_valid) begin
        if (q.size() == 0) begin
          checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          checkOutput("out_data", 32'(out_data), 32'(q[0].data));
          checkOutput("out_carry", 32'(out_carry), 32'(q[0].carry));
          checkOutput("out_zero", 32'(out_zero), 32'(q[0].data == 16'h0));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(refModel(in_data, in_amt, in_op));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    bit ok;
    int idx;

    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = 16'h0;
    in_amt = 16'h0;
    in_op = 2'b00;
    out_ready = 1'b1;

    #12;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_out_carry", 32'(out_carry), 32'd0);
    checkOutput("reset_out_zero", 32'(out_zero), 32'd1);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;

    e = refModel(16'h8001, 16'd1, 2'b00);
    checkOutput("model_sll", 32'({e.carry, e.data}), 32'h1_0002);
    e = refModel(16'h8000, 16'h0014, 2'b10);
    checkOutput("model_sra_sat", 32'({e.carry, e.data}), 32'h1_FFFF);
    e = refModel(16'h8000, 16'h0014, 2'b01);
    checkOutput("model_srl_sat", 32'({e.carry, e.data}), 32'h0_0000);
    e = refModel(16'h1234, 16'h0014, 2'b11);
    checkOutput("model_ror_mod", 32'({e.carry, e.data}), 32'h0_4123);
    e = refModel(16'h00F8, 16'd4, 2'b01);
    checkOutput("model_srl", 32'({e.carry, e.data}), 32'h1_000F);
    e = refModel(16'h0001, 16'd16, 2'b00);
    checkOutput("model_sll_full", 32'({e.carry, e.data}), 32'h1_0000);
    e = refModel(16'h4000, 16'd17, 2'b00);
    checkOutput("model_sll_over", 32'({e.carry, e.data}), 32'h0_0000);
    e = refModel(16'h7FFF, 16'd3, 2'b10);
    checkOutput("model_sra_pos", 32'({e.carry, e.data}), 32'h1_0FFF);

    directedCase("sll_8001_1", 16'h8001, 16'd1, 2'b00, 16'h0002, 1'b1);
    directedCase("sra_sat", 16'h8000, 16'h0014, 2'b10, 16'hFFFF, 1'b1);
    directedCase("srl_sat", 16'h8000, 16'h0014, 2'b01, 16'h0000, 1'b0);
    directedCase("ror_4", 16'h1234, 16'd4, 2'b11, 16'h4123, 1'b0);
    directedCase("ror_20", 16'h1234, 16'h0014, 2'b11, 16'h4123, 1'b0);
    directedCase("ror_16", 16'h1234, 16'd16, 2'b11, 16'h1234, 1'b0);
    directedCase("srl_f8_4", 16'h00F8, 16'd4, 2'b01, 16'h000F, 1'b1);
    directedCase("sll_1_16", 16'h0001, 16'd16, 2'b00, 16'h0000, 1'b1);

    $display("[TB] back-pressure sequence");
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #2;
      end
      out_ready = !(c >= 2 && c <= 5);
      if (idx < 5) begin
        in_valid = 1'b1;
        in_data = 16'h0003;
        in_amt = 16'(idx);
        in_op = 2'b00;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 2 && c <= 5) checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
      if (c >= 6 && c <= 10) checkOutput("bp_throughput", 32'(out_valid && out_ready), 32'd1);
      if (in_valid && in_ready) idx++;
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp_accepted", 32'(idx), 32'd5);
    checkOutput("bp_drained", 32'(q.size()), 32'd0);

    $display("[TB] flush sequence");
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h1234;
    in_amt = 16'd4;
    in_op = 2'b11;
    @(negedge clk);
    checkOutput("flush_accept_a", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    in_data = 16'h00F8;
    in_amt = 16'd2;
    in_op = 2'b01;
    @(negedge clk);
    checkOutput("flush_accept_b", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;
    flush = 1'b1;
    in_data = 16'hABCD;
    in_amt = 16'd1;
    in_op = 2'b00;
    @(negedge clk);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    checkOutput("flush_pre_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #2;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("flush_no_output", 32'(out_valid), 32'd0);
      @(posedge clk);
      #2;
    end
    directedCase("post_flush", 16'h00F8, 16'd4, 2'b01, 16'h000F, 1'b1);

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(16'h8000, 16'd1, 2'b10, ok);
    @(posedge clk);
    #3;
    checkOutput("rst_pre_valid", 32'(out_valid), 32'd1);
    checkOutput("rst_pre_data", 32'(out_data), 32'h0000_C000);
    rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_carry", 32'(out_carry), 32'd0);
    checkOutput("rst_out_zero", 32'(out_zero), 32'd1);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_no_output", 32'(out_valid), 32'd0);
      @(posedge clk);
      #2;
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_data = 16'($urandom);
      case ($urandom_range(0, 3))
        0: in_amt = 16'($urandom_range(0, 20));
        1: in_amt = 16'($urandom);
        2: in_amt = 16'($urandom_range(0, 15));
        default: in_amt = 16'($urandom_range(14, 18));
      endcase
      in_op = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 49) == 0);
      @(posedge clk);
      #2;
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    checkOutput("final_drain", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
